mul_div_unit: RTL and testbench

Iterative multi-cycle RV32M multiply/divide unit in the execute stage, beside the single-cycle combinational ALU. It accepts one operation per transaction over a valid/ready request handshake and computes with a radix-2 shift-add multiplier or a restoring divider, one bit per cycle. It returns the result over a valid/ready response handshake. The pipeline stalls the issuing instruction while `ready_o` is low.

---
 rtl/mul_div_unit_if.sv | 35 +++
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_if
// Description : Request/response bundle between the issue logic and the
//               iterative RV32M multiply/divide unit.
//               Request  : valid_i, ready_o, op_i, operand_a_i, operand_b_i
//               Abort    : flush_i
//               Response : valid_o, ready_i, result_o
//               The unit is the slave; the issuing pipeline is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] operand_a_i;
    logic [WIDTH-1:0] operand_b_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, flush_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiplier and restoring divider working on operand
//               magnitudes, one bit per cycle, followed by a single sign
//               fix-up cycle. Divide-by-zero and signed overflow bypass the
//               iteration and respond one cycle after accept.
// Ports       : clk_i  - clock, rising edge
//               rst_ni - asynchronous active-low reset
//               bus    - request/abort/response bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    mul_div_unit_if.slave bus
);
    localparam int              c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [2:0]      c_OP_MUL    = 3'd0;
    localparam logic [2:0]      c_OP_MULH   = 3'd1;
    localparam logic [2:0]      c_OP_MULHSU = 3'd2;
    localparam logic [2:0]      c_OP_DIV    = 3'd4;
    localparam logic [2:0]      c_OP_REM    = 3'd6;
    localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_op;
    logic             r_neg;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_opnd;    // multiplicand (mul) or divisor (div) magnitude
    logic [WIDTH-1:0] r_hi;      // product high half / remainder
    logic [WIDTH-1:0] r_lo;      // product low half, multiplier / quotient, dividend
    logic [WIDTH-1:0] r_result;

    // ---------------- accept-time decode ----------------
    logic             w_accept, w_is_div, w_a_signed, w_b_signed;
    logic             w_a_neg, w_b_neg, w_sign, w_div_zero, w_overflow, w_special;
    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_special_res;

    assign w_accept   = (r_state == S_IDLE) && bus.valid_i && !bus.flush_i;
    assign w_is_div   = bus.op_i[2];
    assign w_a_signed = (bus.op_i == c_OP_MULH) || (bus.op_i == c_OP_MULHSU) ||
                        (bus.op_i == c_OP_DIV)  || (bus.op_i == c_OP_REM);
    assign w_b_signed = (bus.op_i == c_OP_MULH) || (bus.op_i == c_OP_DIV) ||
                        (bus.op_i == c_OP_REM);
    assign w_a_neg    = w_a_signed && bus.operand_a_i[WIDTH-1];
    assign w_b_neg    = w_b_signed && bus.operand_b_i[WIDTH-1];
    // The most negative value negates to itself, which is still the correct
    // unsigned magnitude.
    assign w_a_abs    = w_a_neg ? -bus.operand_a_i : bus.operand_a_i;
    assign w_b_abs    = w_b_neg ? -bus.operand_b_i : bus.operand_b_i;
    // Remainder takes the dividend's sign; everything else the XOR.
    assign w_sign     = (bus.op_i[2] && bus.op_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = w_is_div && (bus.operand_b_i == '0);
    assign w_overflow = ((bus.op_i == c_OP_DIV) || (bus.op_i == c_OP_REM)) &&
                        (bus.operand_a_i == c_MIN) && (bus.operand_b_i == '1);
    assign w_special  = w_div_zero || w_overflow;
    // op_i[1] separates remainder from quotient within the divide group.
    assign w_special_res = w_div_zero ? (bus.op_i[1] ? bus.operand_a_i : '1)
                                      : (bus.op_i[1] ? '0 : c_MIN);

    // ---------------- per-iteration datapath ----------------
    logic [WIDTH:0] w_sum, w_rem_sh, w_diff;
    logic           w_q_bit;

    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opnd};
    // Shifted remainder is below twice the divisor, so bit WIDTH of the
    // difference is set only when the subtraction borrowed.
    assign w_q_bit  = ~w_diff[WIDTH];

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_res;

    assign w_prod_fix = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};

    always_comb begin
        w_fix_res = '0;
        if (r_op[2]) begin
            if (r_op[1]) w_fix_res = r_neg ? -r_hi : r_hi;
            else         w_fix_res = r_neg ? -r_lo : r_lo;
        end else if (r_op == c_OP_MUL) begin
            w_fix_res = w_prod_fix[WIDTH-1:0];
        end else begin
            w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == c_CNT_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  if (bus.ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush_i) w_state_nxt = S_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= bus.op_i;
            r_neg  <= w_sign;
            r_cnt  <= '0;
            r_opnd <= w_is_div ? w_b_abs : w_a_abs;
            r_hi   <= '0;
            r_lo   <= w_is_div ? w_a_abs : w_b_abs;
            if (w_special) r_result <= w_special_res;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[2]) begin
                r_hi <= w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_q_bit};
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end else if ((r_state == S_FIX) && !bus.flush_i) begin
            // A flushed operation must leave the previous result untouched.
            r_result <= w_fix_res;
        end
    end

    assign bus.ready_o  = (r_state == S_IDLE);
    assign bus.valid_o  = (r_state == S_DONE);
    assign bus.result_o = r_result;
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit. Expected results come
//               from plain 64-bit arithmetic; expected handshake timing from
//               an accept-cycle timestamp. A single negedge process compares
//               ready_o/valid_o/result_o against that model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    localparam int c_LAT = 33;   // accept edge to the edge raising valid_o

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          pending = 1'b0;
    int          exp_valid_cyc = 0;
    logic [31:0] exp_result = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'h0, a};
        logic [63:0] ub = {32'h0, b};
        logic [63:0] p;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa) * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) &&
               a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Cycle-by-cycle comparison against the timing/result model.
    always @(negedge clk) begin
        if (!pending) begin
            chk("ready_idle", {31'h0, bus.ready_o}, 32'd1);
            chk("valid_idle", {31'h0, bus.valid_o}, 32'd0);
        end else if (cyc < exp_valid_cyc) begin
            chk("ready_busy", {31'h0, bus.ready_o}, 32'd0);
            chk("valid_busy", {31'h0, bus.valid_o}, 32'd0);
        end else begin
            chk("ready_done", {31'h0, bus.ready_o}, 32'd0);
            chk("valid_done", {31'h0, bus.valid_o}, 32'd1);
            chk("result",     bus.result_o, exp_result);
        end
    end

    // One transaction. bp: cycles of response backpressure. flush_at >= 0
    // aborts the operation that many cycles into CALC.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int bp, input int flush_at,
                          input bit has_lit, input logic [31:0] lit, input string name);
        bus.op_i = op; bus.operand_a_i = a; bus.operand_b_i = b;
        bus.valid_i = 1'b1; bus.ready_i = (bp == 0);
        @(posedge clk); #1;
        exp_result    = model(op, a, b);
        exp_valid_cyc = cyc + (is_special(op, a, b) ? 0 : c_LAT);
        pending       = 1'b1;
        bus.valid_i   = 1'b0;
        bus.op_i = 3'($urandom_range(0, 7));
        bus.operand_a_i = $urandom; bus.operand_b_i = $urandom;
        if (flush_at >= 0) begin
            repeat (flush_at) begin @(posedge clk); #1; end
            bus.flush_i = 1'b1;
            @(posedge clk); #1;
            bus.flush_i = 1'b0;
            pending = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            return;
        end
        while (cyc < exp_valid_cyc) begin
            @(posedge clk); #1;
            bus.valid_i = 1'($urandom_range(0, 1));
        end
        if (has_lit) chk(name, bus.result_o, lit);
        repeat (bp) begin
            @(posedge clk); #1;
            bus.valid_i = 1'($urandom_range(0, 1));
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        pending = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return $urandom_range(0, 20);
            2:       return 32'h0;
            3:       return 32'h8000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    initial begin
        #400_000;
        $display("FAIL watchdog actual=%0d required=<%0d", cyc, 40000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.valid_i = 0; bus.op_i = 0; bus.operand_a_i = 0; bus.operand_b_i = 0;
        bus.flush_i = 0; bus.ready_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.result_o, 32'h0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0, -1, 1, 32'hFFFF_FFEB, "mul_7xm3");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0, -1, 1, 32'h4000_0000, "mulh_min");
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, -1, 1, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, -1, 1, 32'hFFFF_FFFE, "mulhu_max");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0, -1, 1, 32'hFFFF_FFFD, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0, -1, 1, 32'hFFFF_FFFF, "rem_m7_2");
        run_op(3'd5, 32'd100,        32'd7,         0, -1, 1, 32'd14,        "divu_100_7");
        run_op(3'd7, 32'd100,        32'd7,         0, -1, 1, 32'd2,         "remu_100_7");
        run_op(3'd5, 32'h1234,       32'h0,         0, -1, 1, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'd6, 32'h1234,       32'h0,         0, -1, 1, 32'h1234,      "rem_by0");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0, -1, 1, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0, -1, 1, 32'h0,         "rem_ovf");

        // Backpressure in DONE with valid_i pulses.
        run_op(3'd1, 32'h1234_5678,  32'hFEDC_BA98, 5, -1, 0, 32'h0, "");
        run_op(3'd6, 32'd9,          32'd0,         5, -1, 0, 32'h0, "");

        // Flush in CALC cycle 10.
        run_op(3'd0, 32'd1000,       32'd1000,      0, 10, 0, 32'h0, "");

        // Flush together with a request in IDLE: must not accept.
        bus.op_i = 3'd0; bus.operand_a_i = 32'd2; bus.operand_b_i = 32'd2;
        bus.valid_i = 1'b1; bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0; bus.flush_i = 1'b0;
        chk("flush_no_accept", {31'h0, bus.ready_o}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end

        // Asynchronous reset in the middle of CALC.
        bus.op_i = 3'd0; bus.operand_a_i = 32'd77; bus.operand_b_i = 32'd99;
        bus.valid_i = 1'b1; bus.ready_i = 1'b1;
        @(posedge clk); #1;
        exp_result = model(3'd0, 32'd77, 32'd99);
        exp_valid_cyc = cyc + c_LAT;
        pending = 1'b1;
        bus.valid_i = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        rst_ni = 1'b0;
        pending = 1'b0;
        #1;
        chk("rst_ready",  {31'h0, bus.ready_o}, 32'd1);
        chk("rst_valid",  {31'h0, bus.valid_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd5, 0, -1, 1, 32'd15, "mul_3x5");

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a  = pick();
            logic [31:0] b  = pick();
            int          fl = -1;
            if (!is_special(op, a, b) && $urandom_range(0, 9) == 0)
                fl = $urandom_range(0, 32);
            run_op(op, a, b, $urandom_range(0, 3), fl, 0, 32'h0, "");
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
